mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester and its load/store requester.
- Sits between the compute core's external fetch/data interfaces and a single-ported memory or bus with a request/grant handshake and a variable-latency response.
- Data accesses have fixed priority over fetches; a saturating starvation counter forces a fetch grant after MAX_WAIT consecutive lost arbitrations.
- One transaction is outstanding at a time.

Parameters:
- XLEN, 32, datapath/address width (32 or 64).
- MAX_WAIT, 4, number of consecutive cycles fetch may lose arbitration before it is forced to win (1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- IReq  input  1  fetch request; held with IAdr until IDone.
- IAdr  input  XLEN  fetch address.
- IRdata  output  32  fetch data, MemRdata[31:0]; valid only when IDone=1.
- IDone  output  1  one-cycle fetch completion pulse.
- DReq  input  1  data request; held with its payload until DDone.
- DWriteEn  input  1  1 = store, 0 = load.
- DByteEn  input  XLEN/8  store byte strobes.
- DAdr  input  XLEN  data address.
- DWdata  input  XLEN  store data.
- DRdata  output  XLEN  load data; valid only when DDone=1.
- DDone  output  1  one-cycle data completion pulse (loads and stores).
- MemReq  output  1  memory request; held until MemGnt.
- MemWriteEn  output  1  store qualifier.
- MemByteEn  output  XLEN/8  strobes; forced to 0 when MemWriteEn=0.
- MemAdr  output  XLEN  memory address.
- MemWdata  output  XLEN  memory write data.
- MemGnt  input  1  memory accepted the request this cycle.
- MemRValid  input  1  response/completion from memory; stores also receive one.
- MemRdata  input  XLEN  response data.

Behaviour:
- Reset:
  - State = IDLE; outbound registers cleared.
  - MemReq, IDone, DDone, MemWriteEn, MemByteEn, IRdata, DRdata and the starvation counter are all 0.
  - Reset mid-transaction abandons it; any later MemRValid arriving while in IDLE is ignored.
- States:
  - IDLE: if any request is present, latch the winner's address, data, write enable and byte enables into the outbound registers, record the owner, and go to ISSUE.
  - ISSUE: MemReq=1 with stable outbound registers. On MemGnt go to WAIT; otherwise stay.
  - WAIT: MemReq=0. When MemRValid=1, pulse the owner's Done combinationally that same cycle, pass MemRdata through to the owner's data output, and go to IDLE.
- Arbitration in IDLE:
  - DReq only: data wins. IReq only: fetch wins.
  - Both: data wins unless StarveCnt == MAX_WAIT, in which case fetch wins.
- Starvation counter:
  - StarveCnt increments, saturating at MAX_WAIT, on every IDLE cycle where IReq=1 and data wins.
  - Clears to 0 on a fetch grant.
  - Holds in ISSUE and WAIT.
- Latency:
  - Request seen in IDLE at cycle N; MemReq asserted at N+1.
  - With MemGnt at N+1 and MemRValid at N+2, Done pulses at N+2.
  - Next arbitration occurs at N+3. Throughput is at most one access per 3 cycles.
- Requester rules:
  - A request still high in the cycle after its Done is treated as a new request.
  - Request inputs are sampled only in IDLE; changes during ISSUE/WAIT have no effect.
- Done outputs: IDone and DDone are never asserted together, and never outside WAIT.
- Protocol violations: MemRValid during ISSUE or IDLE is ignored. A simultaneous MemGnt and MemRValid in ISSUE counts as a grant only; the response must arrive in WAIT.

Decomposition:
- Shared package arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT};
  - owner enum owner_t {OWN_I, OWN_D};
  - starvation counter width localparam.
- Sub-module mem_arb_pick: combinational winner select plus the saturating starvation counter register.

Test Plan:
- Fetch only: IReq=1, IAdr=0x100, MemGnt immediate, MemRValid one cycle later with MemRdata=0x00000093 -> MemAdr=0x100 with MemReq for one cycle; IDone pulses with IRdata=0x93 at cycle 2.
- Store: DReq=1, DWriteEn=1, DAdr=0x2004, DByteEn=4'b0011, DWdata=0xBEEF -> MemWriteEn=1, MemByteEn=0011, MemWdata=0xBEEF; DDone pulses on MemRValid.
- Contention: IReq and DReq held continuously -> data wins 4 consecutive arbitrations, the 5th grant goes to fetch, then the counter restarts.
- Grant stall: MemGnt held low for 5 cycles -> MemReq and the payload stay stable for 6 cycles; no Done is asserted.
- Reset in WAIT: reset during an outstanding load, then MemRValid=1 after reset -> no DDone, all outputs 0, state IDLE.
- Load with DByteEn=4'b1111 and DWriteEn=0 -> MemByteEn=0 and MemWriteEn=0; DRdata equals MemRdata (0xCAFEF00D) on DDone.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, transaction
// owner, and the width of the fetch starvation counter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Wide enough for MAX_WAIT up to 15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals seen by the
// arbiter. The arbiter uses the master view; its environment uses the slave view.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);

  // Instruction-fetch requester
  logic              IReq;
  logic [XLEN-1:0]   IAdr;
  logic [31:0]       IRdata;
  logic              IDone;

  // Load/store requester
  logic              DReq;
  logic              DWriteEn;
  logic [XLEN/8-1:0] DByteEn;
  logic [XLEN-1:0]   DAdr;
  logic [XLEN-1:0]   DWdata;
  logic [XLEN-1:0]   DRdata;
  logic              DDone;

  // Shared memory port
  logic              MemReq;
  logic              MemWriteEn;
  logic [XLEN/8-1:0] MemByteEn;
  logic [XLEN-1:0]   MemAdr;
  logic [XLEN-1:0]   MemWdata;
  logic              MemGnt;
  logic              MemRValid;
  logic [XLEN-1:0]   MemRdata;

  modport master (
    input  IReq, IAdr,
    output IRdata, IDone,
    input  DReq, DWriteEn, DByteEn, DAdr, DWdata,
    output DRdata, DDone,
    output MemReq, MemWriteEn, MemByteEn, MemAdr, MemWdata,
    input  MemGnt, MemRValid, MemRdata
  );

  modport slave (
    output IReq, IAdr,
    input  IRdata, IDone,
    output DReq, DWriteEn, DByteEn, DAdr, DWdata,
    input  DRdata, DDone,
    input  MemReq, MemWriteEn, MemByteEn, MemAdr, MemWdata,
    output MemGnt, MemRValid, MemRdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner select for the shared memory port: data has fixed priority, but a
// fetch that has lost MAX_WAIT arbitrations in a row is forced through.
module mem_arb_pick
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   arb_en_i,   // high only while the arbiter sits in IDLE
  input  logic   ireq_i,
  input  logic   dreq_i,
  output logic   grant_o,    // some requester wins this cycle
  output owner_t owner_o
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                fetch_forced;

  // Pick the winner and work out the next starvation count.
  always_comb begin
    grant_o      = ireq_i | dreq_i;
    fetch_forced = (starve_q == MAX_CNT);
    owner_o      = (dreq_i && !(ireq_i && fetch_forced)) ? OWN_D : OWN_I;

    starve_d = starve_q;
    if (arb_en_i && grant_o) begin
      if (owner_o == OWN_I) begin
        starve_d = '0;
      end else if (ireq_i && (starve_q != MAX_CNT)) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  // Starvation counter register; only moves during IDLE arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/grant memory port between instruction fetch and
// load/store. One transaction is in flight at a time: IDLE picks and latches
// a winner, ISSUE holds MemReq until granted, WAIT forwards the response.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  arb_state_t        state_q;
  owner_t            owner_q;
  logic [XLEN-1:0]   adr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic [XLEN/8-1:0] be_q;

  logic   pick_grant;
  owner_t pick_owner;
  logic   resp_hit;

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .arb_en_i (state_q == IDLE),
    .ireq_i   (bus.IReq),
    .dreq_i   (bus.DReq),
    .grant_o  (pick_grant),
    .owner_o  (pick_owner)
  );

  // Transaction FSM; the outbound payload is captured once in IDLE and held
  // untouched through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_grant) begin
            owner_q <= pick_owner;
            if (pick_owner == OWN_D) begin
              adr_q   <= bus.DAdr;
              wdata_q <= bus.DWdata;
              we_q    <= bus.DWriteEn;
              be_q    <= bus.DWriteEn ? bus.DByteEn : '0;
            end else begin
              adr_q   <= bus.IAdr;
              wdata_q <= '0;
              we_q    <= 1'b0;
              be_q    <= '0;
            end
            state_q <= ISSUE;
          end
        end
        // A response arriving alongside the grant is not a completion.
        ISSUE: begin
          if (bus.MemGnt) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.MemRValid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion is combinational on MemRValid so Done lands in the response cycle.
  always_comb begin
    resp_hit       = (state_q == WAIT) && bus.MemRValid;
    bus.IDone      = resp_hit && (owner_q == OWN_I);
    bus.DDone      = resp_hit && (owner_q == OWN_D);
    bus.IRdata     = bus.IDone ? bus.MemRdata[31:0] : '0;
    bus.DRdata     = bus.DDone ? bus.MemRdata : '0;
    bus.MemReq     = (state_q == ISSUE);
    bus.MemWriteEn = we_q;
    bus.MemByteEn  = we_q ? be_q : '0;
    bus.MemAdr     = adr_q;
    bus.MemWdata   = wdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a scoreboard of expected memory-side payloads
// and completions, filled when requests are driven and drained as the DUT
// completes each transaction.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(32)) bus();

  mem_port_arbiter #(
    .XLEN     (32),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input-drive phase).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic [31:0] adr, input logic [31:0] rd);
    exp_t e;
    e.is_d = 1'b0; e.adr = adr; e.we = 1'b0; e.be = 4'h0; e.wdata = '0; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] adr, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.is_d = 1'b1; e.adr = adr; e.we = we; e.be = we ? be : 4'h0; e.wdata = wd; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // Serve one transaction: wait for MemReq, hold off the grant for 'stall'
  // cycles, then grant; optionally raise a bogus MemRValid with the grant;
  // spend 'gap' cycles in WAIT before the response. Ends in the IDLE cycle
  // after Done, at the input-drive phase.
  task automatic run_txn(input int stall, input bit rv_on_gnt, input int gap);
    exp_t e;
    int   n = 0;
    while (bus.MemReq !== 1'b1 && n < 12) begin
      tick();
      #1;
      n++;
    end
    check_eq("req_latency", n, 1);
    check_eq("sb_nonempty", (sb_q.size() != 0), 1);
    if (bus.MemReq !== 1'b1 || sb_q.size() == 0) return;
    e = sb_q.pop_front();
    for (int k = 0; k <= stall; k++) begin
      bus.MemGnt    = (k == stall);
      bus.MemRValid = (k == stall) && rv_on_gnt;
      bus.MemRdata  = 32'hDEAD_0000;
      #1;
      check_eq("issue_memreq", bus.MemReq, 1);
      check_eq("issue_adr", bus.MemAdr, e.adr);
      check_eq("issue_we", bus.MemWriteEn, e.we);
      check_eq("issue_be", bus.MemByteEn, e.be);
      if (e.we) check_eq("issue_wdata", bus.MemWdata, e.wdata);
      check_eq("issue_no_done", {bus.IDone, bus.DDone}, 0);
      tick();
    end
    bus.MemGnt    = 1'b0;
    bus.MemRValid = 1'b0;
    for (int k = 0; k < gap; k++) begin
      #1;
      check_eq("wait_memreq", bus.MemReq, 0);
      check_eq("wait_no_done", {bus.IDone, bus.DDone}, 0);
      tick();
    end
    bus.MemRValid = 1'b1;
    bus.MemRdata  = e.rdata;
    #1;
    check_eq("resp_memreq", bus.MemReq, 0);
    check_eq("resp_idone", bus.IDone, !e.is_d);
    check_eq("resp_ddone", bus.DDone, e.is_d);
    if (e.is_d) check_eq("resp_drdata", bus.DRdata, e.rdata);
    else        check_eq("resp_irdata", bus.IRdata, e.rdata);
    tick();
    bus.MemRValid = 1'b0;
    bus.MemRdata  = '0;
    $display("txn %s adr=0x%0h we=%0d be=0x%0h rdata=0x%0h done", e.is_d ? "D" : "I",
             e.adr, e.we, e.be, e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.IReq = 0; bus.IAdr = '0;
    bus.DReq = 0; bus.DWriteEn = 0; bus.DByteEn = '0; bus.DAdr = '0; bus.DWdata = '0;
    bus.MemGnt = 0; bus.MemRValid = 0; bus.MemRdata = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    #1;
    check_eq("rst_memreq", bus.MemReq, 0);
    check_eq("rst_done", {bus.IDone, bus.DDone}, 0);
    check_eq("rst_we", bus.MemWriteEn, 0);
    check_eq("rst_be", bus.MemByteEn, 0);
    check_eq("rst_irdata", bus.IRdata, 0);
    check_eq("rst_drdata", bus.DRdata, 0);
    tick();
    rst = 1'b0;

    // Fetch only, immediate grant and response
    bus.IReq = 1; bus.IAdr = 32'h100;
    push_i(32'h100, 32'h0000_0093);
    #1;
    run_txn(0, 0, 0);
    bus.IReq = 0;

    // Store with partial strobes
    bus.DReq = 1; bus.DWriteEn = 1; bus.DAdr = 32'h2004; bus.DByteEn = 4'b0011; bus.DWdata = 32'hBEEF;
    push_d(32'h2004, 1'b1, 4'b0011, 32'hBEEF, 32'h0);
    #1;
    run_txn(0, 0, 1);
    bus.DReq = 0; bus.DWriteEn = 0;

    // Load: strobes must be masked off
    bus.DReq = 1; bus.DWriteEn = 0; bus.DAdr = 32'h3000; bus.DByteEn = 4'b1111; bus.DWdata = 32'h1234_5678;
    push_d(32'h3000, 1'b0, 4'b1111, 32'h1234_5678, 32'hCAFE_F00D);
    #1;
    run_txn(0, 0, 0);
    bus.DReq = 0;

    // Grant stall: five cycles without MemGnt
    bus.IReq = 1; bus.IAdr = 32'h240;
    push_i(32'h240, 32'h1111_2222);
    #1;
    run_txn(5, 0, 2);
    bus.IReq = 0;

    // MemRValid together with MemGnt counts only as the grant
    bus.DReq = 1; bus.DWriteEn = 0; bus.DAdr = 32'h4000; bus.DByteEn = 4'b0101;
    push_d(32'h4000, 1'b0, 4'b0101, 32'h0, 32'h55AA_55AA);
    #1;
    run_txn(0, 1, 1);
    bus.DReq = 0;

    // Contention: both requesters held; 4 data wins then a forced fetch, twice
    bus.IReq = 1; bus.IAdr = 32'h500;
    bus.DReq = 1; bus.DWriteEn = 0; bus.DAdr = 32'h600; bus.DByteEn = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push_i(32'h500, 32'h1000 + i);
      else            push_d(32'h600, 1'b0, 4'hF, 32'h0, 32'h2000 + i);
    end
    #1;
    for (int i = 0; i < 10; i++) run_txn(0, 0, 0);
    bus.IReq = 0; bus.DReq = 0;

    // Reset while a load waits for its response
    bus.DReq = 1; bus.DWriteEn = 0; bus.DAdr = 32'h700; bus.DByteEn = 4'hF;
    #1;
    n = 0;
    while (bus.MemReq !== 1'b1 && n < 12) begin
      tick();
      #1;
      n++;
    end
    check_eq("rw_memreq", bus.MemReq, 1);
    bus.MemGnt = 1;
    tick();
    bus.MemGnt = 0; bus.DReq = 0;
    rst = 1'b1;
    #1;
    check_eq("rw_wait_memreq", bus.MemReq, 0);
    tick();
    rst = 1'b0;
    bus.MemRValid = 1; bus.MemRdata = 32'hCAFE_F00D;
    #1;
    check_eq("rw_no_ddone", bus.DDone, 0);
    check_eq("rw_no_idone", bus.IDone, 0);
    check_eq("rw_drdata", bus.DRdata, 0);
    check_eq("rw_memreq0", bus.MemReq, 0);
    check_eq("rw_we", bus.MemWriteEn, 0);
    check_eq("rw_be", bus.MemByteEn, 0);
    check_eq("rw_adr", bus.MemAdr, 0);
    tick();
    bus.MemRValid = 0; bus.MemRdata = '0;
    #1;
    check_eq("rw_idle_memreq", bus.MemReq, 0);
    $display("txn reset-in-WAIT: stray response ignored");
    tick();

    // Normal fetch after the abandoned load
    bus.IReq = 1; bus.IAdr = 32'h800;
    push_i(32'h800, 32'h0BAD_CAFE);
    #1;
    run_txn(0, 0, 0);
    bus.IReq = 0;
    tick();
    check_eq("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
